mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction and data request streams of two cores.
- Each core's request unit presents iREN/dREN/dWEN plus addresses.
- The arbiter picks one requester, holds it on the RAM port until the RAM reports ACCESS, then returns the load data and a one-cycle wait release.
- Sits between the per-core cache/request logic and the RAM model, in the memory-control slot.

Parameters:
- NCORES, 2, number of cores; only 2 is supported, and elaboration must fail on any other value.
- TIMEOUT, 64, max cycles in BUSY without ACCESS before the transaction is aborted.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  reset; synchronous, active-low; sampled on posedge CLK.
- iREN  in  [NCORES]  instruction read request per core.
- iaddr  in  [NCORES] x word_t  instruction address per core.
- dREN  in  [NCORES]  data read request per core.
- dWEN  in  [NCORES]  data write request per core.
- daddr  in  [NCORES] x word_t  data address per core.
- dstore  in  [NCORES] x word_t  data write value per core.
- iwait  out  [NCORES]  1 = instruction request not complete this cycle.
- dwait  out  [NCORES]  1 = data request not complete this cycle.
- iload  out  [NCORES] x word_t  instruction read data; valid when iwait=0 and iREN=1.
- dload  out  [NCORES] x word_t  data read data; valid when dwait=0 and dREN=1.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  word_t  RAM address.
- ramstore  out  word_t  RAM write data.
- ramload  in  word_t  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.
- timeout_err  out  1  sticky flag, set when a watchdog abort occurs.

Behaviour:
- Reset (nRST=0 at posedge): state=IDLE, rr_ptr=0, timer=0, timeout_err=0.
- Request vector: src0=core0 data, src1=core1 data, src2=core0 instr, src3=core1 instr.
- Data requests (dREN|dWEN) beat instruction requests.
- Within a class, the core equal to rr_ptr wins; rr_ptr flips after every completed (ACCESS) grant.
- If dWEN and dREN are both high on one core, the transaction is a write.
- States: IDLE, BUSY.
  - IDLE: if any request is present, latch the winner (src, addr, store, write flag) and go to BUSY next cycle. The RAM port is undriven in IDLE (ramREN=ramWEN=0, addr/store=0).
  - BUSY: drive ramREN/ramWEN/ramaddr/ramstore from the latched winner; timer increments each cycle.
    - ramstate==ACCESS: in the same cycle, deassert the winner's wait, drive its load from ramload, flip rr_ptr, clear timer, go to IDLE.
    - ramstate==ERROR: go to IDLE; wait stays high, so the request is retried by re-arbitration.
    - Latched requester's enable drops (abort, e.g. pipeline flush): go to IDLE next cycle, no completion, rr_ptr unchanged.
    - timer reaches TIMEOUT-1 without ACCESS: go to IDLE, set timeout_err (sticky until reset), clear timer.
- Completion is never reported from IDLE, so there is a minimum 2-cycle turnaround per transaction and no back-to-back ACCESS reuse.
- Wait outputs: for each core/type, wait = enable & ~(completing this cycle). With no request, wait=0.
- iload/dload are 0 when not completing.
- A new request arriving in the same cycle as another's ACCESS is considered in the next IDLE cycle.
- Reset asserted mid-BUSY: next state IDLE and RAM enables drop; the in-flight write may be partial and the RAM owner handles it.
- Address/store latching: changes on daddr/iaddr during BUSY are ignored until the next IDLE.

Decomposition:
- cpu_types_pkg holds word_t (32-bit logic), ramstate_t enum (FREE, BUSY, ACCESS, ERROR), and arbiter state enum arb_state_t (IDLE, BUSY).
- One natural sub-module: rr_picker, which is combinational. Inputs: 4 request bits + rr_ptr. Outputs: one-hot grant + write flag.
- Interface mem_arbiter_if bundles the ports, with modports arb, core, ram.

Test Plan:
- Reset then core0 iREN=1, iaddr=0x100, and the RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF. Required: ramaddr=0x100 and ramREN=1 during BUSY; iwait[0]=0 and iload[0]=0xDEADBEEF for exactly 1 cycle.
- core0 iREN and core1 dWEN (daddr=0x200, dstore=0x55) asserted together. Required: the write is granted first (ramWEN=1, ramaddr=0x200, ramstore=0x55), then core0's instruction read.
- Both cores hold dREN continuously with instant ACCESS. Required: grants alternate core0, core1, core0, core1, and each dwait drops once per 2-cycle slot.
- Latched core1 drops dREN mid-BUSY. Required: IDLE next cycle, no dwait release, and rr_ptr unchanged (next tie still goes to core1).
- ramstate held at BUSY for TIMEOUT cycles. Required: return to IDLE, timeout_err=1 stays set, iwait still 1, and the request is re-granted next.
- nRST=0 asserted mid-BUSY with ramWEN=1. Required: at the next posedge ramWEN=0, state=IDLE, timeout_err=0, and all waits reflect only the live enables.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake states, arbiter states
// and the two-way round-robin helper used by the request picker.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Prefixed so the arbiter's BUSY does not collide with the RAM's BUSY.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Source order: core0 data, core1 data, core0 instr, core1 instr.
    localparam int NSRC = 4;

    function automatic logic [1:0] pick2(input logic [1:0] req, input logic ptr);
        logic [1:0] g;
        g = 2'b00;
        if (req[ptr]) begin
            g[ptr] = 1'b1;
        end else if (req[~ptr]) begin
            g[~ptr] = 1'b1;
        end else begin
            g = 2'b00;
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Port bundle for the memory arbiter with views for the arbiter itself,
// the per-core request units and the RAM model.
interface mem_arbiter_if
    import cpu_types_pkg::*;
#(
    parameter int NCORES = 2
) (
    input logic CLK
);
    logic                     nRST;
    logic      [NCORES-1:0]   iREN;
    word_t     [NCORES-1:0]   iaddr;
    logic      [NCORES-1:0]   dREN;
    logic      [NCORES-1:0]   dWEN;
    word_t     [NCORES-1:0]   daddr;
    word_t     [NCORES-1:0]   dstore;
    logic      [NCORES-1:0]   iwait;
    logic      [NCORES-1:0]   dwait;
    word_t     [NCORES-1:0]   iload;
    word_t     [NCORES-1:0]   dload;
    logic                     ramREN;
    logic                     ramWEN;
    word_t                    ramaddr;
    word_t                    ramstore;
    word_t                    ramload;
    ramstate_t                ramstate;
    logic                     timeout_err;

    modport arb (
        input  CLK, nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, timeout_err
    );

    modport core (
        input  CLK, iwait, dwait, iload, dload,
        output iREN, iaddr, dREN, dWEN, daddr, dstore
    );

    modport ram (
        input  CLK, ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational winner selection: data beats instruction, and within a class
// the core named by the round-robin pointer wins a tie.
module rr_picker
    import cpu_types_pkg::*;
(
    input  logic [NSRC-1:0] req,
    input  logic [1:0]      dwen,
    input  logic            rr_ptr,
    output logic [NSRC-1:0] grant,
    output logic            write
);

    // Class priority then round-robin within the class.
    always_comb begin
        grant = 4'b0000;
        if (|req[1:0]) begin
            grant = {2'b00, pick2(req[1:0], rr_ptr)};
        end else if (|req[3:2]) begin
            grant = {pick2(req[3:2], rr_ptr), 2'b00};
        end else begin
            grant = 4'b0000;
        end
        write = |(grant[1:0] & dwen);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-core memory arbiter: grants one of four request streams to the single
// RAM port and holds it until ACCESS, ERROR, abort or watchdog expiry.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NCORES  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic  [NCORES-1:0]   iREN,
    input  word_t [NCORES-1:0]   iaddr,
    input  logic  [NCORES-1:0]   dREN,
    input  logic  [NCORES-1:0]   dWEN,
    input  word_t [NCORES-1:0]   daddr,
    input  word_t [NCORES-1:0]   dstore,
    output logic  [NCORES-1:0]   iwait,
    output logic  [NCORES-1:0]   dwait,
    output word_t [NCORES-1:0]   iload,
    output word_t [NCORES-1:0]   dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output word_t                ramaddr,
    output word_t                ramstore,
    input  word_t                ramload,
    input  ramstate_t            ramstate,
    output logic                 timeout_err
);

    if (NCORES != 2) begin : g_ncores_check
        $error("mem_arbiter supports only NCORES = 2");
    end

    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t      state_r, state_nxt_s;
    logic            rr_ptr_r, rr_ptr_nxt_s;
    logic [TW-1:0]   timer_r, timer_nxt_s;
    logic            timeout_err_r, timeout_err_nxt_s;
    logic [NSRC-1:0] grant_r, grant_nxt_s;
    word_t           addr_r, addr_nxt_s;
    word_t           store_r, store_nxt_s;
    logic            write_r, write_nxt_s;

    logic [NSRC-1:0] req_s, pick_grant_s, done_s;
    logic            pick_write_s, live_s, complete_s, busy_s;
    word_t           pick_addr_s, pick_store_s;

    assign req_s  = {iREN[1], iREN[0], dREN[1] | dWEN[1], dREN[0] | dWEN[0]};
    assign live_s = |(grant_r & req_s);
    assign busy_s = (state_r == ARB_BUSY);

    rr_picker u_picker (
        .req    (req_s),
        .dwen   (dWEN[1:0]),
        .rr_ptr (rr_ptr_r),
        .grant  (pick_grant_s),
        .write  (pick_write_s)
    );

    // Address and store value belonging to the picked source.
    always_comb begin
        pick_addr_s  = 32'h0000_0000;
        pick_store_s = 32'h0000_0000;
        case (pick_grant_s)
            4'b0001: begin pick_addr_s = daddr[0]; pick_store_s = dstore[0]; end
            4'b0010: begin pick_addr_s = daddr[1]; pick_store_s = dstore[1]; end
            4'b0100: begin pick_addr_s = iaddr[0]; end
            4'b1000: begin pick_addr_s = iaddr[1]; end
            default: begin pick_addr_s = 32'h0000_0000; pick_store_s = 32'h0000_0000; end
        endcase
    end

    // Next-state logic: latch a winner in IDLE, resolve the transaction in BUSY.
    always_comb begin
        state_nxt_s       = state_r;
        rr_ptr_nxt_s      = rr_ptr_r;
        timer_nxt_s       = timer_r;
        timeout_err_nxt_s = timeout_err_r;
        grant_nxt_s       = grant_r;
        addr_nxt_s        = addr_r;
        store_nxt_s       = store_r;
        write_nxt_s       = write_r;
        complete_s        = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (|req_s) begin
                    grant_nxt_s = pick_grant_s;
                    addr_nxt_s  = pick_addr_s;
                    store_nxt_s = pick_store_s;
                    write_nxt_s = pick_write_s;
                    timer_nxt_s = {TW{1'b0}};
                    state_nxt_s = ARB_BUSY;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                timer_nxt_s = timer_r + TW'(1);
                // A dropped enable is an abort even if the RAM answers now.
                if (!live_s) begin
                    state_nxt_s = ARB_IDLE;
                    timer_nxt_s = {TW{1'b0}};
                end else if (ramstate == ACCESS) begin
                    complete_s   = 1'b1;
                    rr_ptr_nxt_s = ~rr_ptr_r;
                    state_nxt_s  = ARB_IDLE;
                    timer_nxt_s  = {TW{1'b0}};
                end else if (ramstate == ERROR) begin
                    state_nxt_s = ARB_IDLE;
                    timer_nxt_s = {TW{1'b0}};
                end else if (timer_r == TW'(TIMEOUT - 1)) begin
                    state_nxt_s       = ARB_IDLE;
                    timeout_err_nxt_s = 1'b1;
                    timer_nxt_s       = {TW{1'b0}};
                end else begin
                    state_nxt_s = ARB_BUSY;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
                timer_nxt_s = {TW{1'b0}};
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r       <= ARB_IDLE;
            rr_ptr_r      <= 1'b0;
            timer_r       <= {TW{1'b0}};
            timeout_err_r <= 1'b0;
            grant_r       <= 4'b0000;
            addr_r        <= 32'h0000_0000;
            store_r       <= 32'h0000_0000;
            write_r       <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            rr_ptr_r      <= rr_ptr_nxt_s;
            timer_r       <= timer_nxt_s;
            timeout_err_r <= timeout_err_nxt_s;
            grant_r       <= grant_nxt_s;
            addr_r        <= addr_nxt_s;
            store_r       <= store_nxt_s;
            write_r       <= write_nxt_s;
        end
    end

    // RAM port driven only in BUSY; waits and loads released on completion.
    always_comb begin
        ramREN      = busy_s & ~write_r;
        ramWEN      = busy_s & write_r;
        ramaddr     = busy_s ? addr_r : 32'h0000_0000;
        ramstore    = busy_s ? store_r : 32'h0000_0000;
        done_s      = complete_s ? grant_r : 4'b0000;
        dwait       = req_s[1:0] & ~done_s[1:0];
        iwait       = iREN & ~done_s[3:2];
        dload[0]    = done_s[0] ? ramload : 32'h0000_0000;
        dload[1]    = done_s[1] ? ramload : 32'h0000_0000;
        iload[0]    = done_s[2] ? ramload : 32'h0000_0000;
        iload[1]    = done_s[3] ? ramload : 32'h0000_0000;
        timeout_err = timeout_err_r;
    end

endmodule
